// File: rtl/instr_mem_loader.sv
// Instruction memory loader: encodes MIPS R-type/lw/sw/beq words from decoded
// fields and writes them to consecutive imem word addresses, keeping the CPU
// in reset until the whole program has been written.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready
// are both 1. in_ready is registered and is 1 only while in LOAD. The producer
// holds its fields stable while in_valid=1 and in_ready=0. in_valid in any
// other state is ignored and never written.
module instr_mem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              load_done,
    output logic              cpu_rst_n
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

    localparam logic [1:0] KIND_R   = 2'b00;
    localparam logic [1:0] KIND_LW  = 2'b01;
    localparam logic [1:0] KIND_SW  = 2'b10;
    localparam logic [1:0] KIND_BEQ = 2'b11;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;

    logic        accept;
    logic        at_top;
    logic [31:0] enc_word;

    assign accept = in_valid && in_ready;
    assign at_top = (word_count == LAST_ADDR);

    // Encode the incoming beat; shamt is always zero, unused fields are dropped.
    always_comb begin
        enc_word = 32'h0;
        case (in_kind)
            KIND_R:   enc_word = {OP_R, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            KIND_LW:  enc_word = {OP_LW, in_rs, in_rt, in_imm};
            KIND_SW:  enc_word = {OP_SW, in_rs, in_rt, in_imm};
            KIND_BEQ: enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
            default:  enc_word = 32'h0;
        endcase
    end

    // Session FSM with all outputs registered; reset aborts any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            word_count <= '0;
            overflow   <= 1'b0;
            load_done  <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        load_done  <= 1'b0;
                        cpu_rst_n  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= enc_word;
                        word_count <= word_count + COUNT_ONE;
                        // Top address is the last slot: stop even without in_last.
                        if (in_last || at_top) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                            overflow <= at_top && !in_last;
                        end
                    end
                end
                DRAIN: begin
                    // The final write strobe is visible this cycle; release next.
                    state     <= DONE;
                    load_done <= 1'b1;
                    cpu_rst_n <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default-depth instance (a_*) for the
// main sessions and a 4-word instance (b_*) for the fill/overflow boundary.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic in_valid;
    logic [1:0] in_kind;
    logic [4:0] in_rs, in_rt, in_rd;
    logic [5:0] in_funct;
    logic [15:0] in_imm;
    logic in_last;

    logic a_ready, a_we, a_ovf, a_done, a_cpu;
    logic [5:0] a_addr;
    logic [31:0] a_wdata;
    logic [6:0] a_count;

    logic b_ready, b_we, b_ovf, b_done, b_cpu;
    logic [1:0] b_addr;
    logic [31:0] b_wdata;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in_valid(in_valid), .in_ready(a_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .word_count(a_count), .overflow(a_ovf), .load_done(a_done),
        .cpu_rst_n(a_cpu)
    );

    instr_mem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in_valid(in_valid), .in_ready(b_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .word_count(b_count), .overflow(b_ovf), .load_done(b_done),
        .cpu_rst_n(b_cpu)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic last);
        in_valid = 1'b1;
        in_kind  = kind;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_funct = funct;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check a write strobe of instance a.
    task automatic chk_wr_a(input string tag, input logic [5:0] addr, input logic [31:0] data);
        check({tag, "_we"}, {31'b0, a_we}, 32'd1);
        check({tag, "_addr"}, {26'b0, a_addr}, {26'b0, addr});
        check({tag, "_data"}, a_wdata, data);
    endtask

    initial begin
        rst_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        in_valid = 1'b0;
        in_kind = 2'b00;
        in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
        in_last = 1'b0;

        // ---- 1: reset state ----
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'b0, a_ready}, 32'd0);
        check("rst_we", {31'b0, a_we}, 32'd0);
        check("rst_addr", {26'b0, a_addr}, 32'd0);
        check("rst_wdata", a_wdata, 32'd0);
        check("rst_count", {25'b0, a_count}, 32'd0);
        check("rst_ovf", {31'b0, a_ovf}, 32'd0);
        check("rst_done", {31'b0, a_done}, 32'd0);
        check("rst_cpu", {31'b0, a_cpu}, 32'd0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;  // ignored in IDLE
        tick();
        tick();
        check("idle_ready", {31'b0, a_ready}, 32'd0);
        check("idle_we", {31'b0, a_we}, 32'd0);
        check("idle_cpu", {31'b0, a_cpu}, 32'd0);
        check("idle_count", {25'b0, a_count}, 32'd0);
        in_valid = 1'b0;

        // ---- 2: single R-type program ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t2_ready", {31'b0, a_ready}, 32'd1);
        beat(2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF, 1'b1);
        tick();
        idle_in();
        chk_wr_a("t2_wr", 6'd0, 32'h00221820);
        check("t2_cpu_held", {31'b0, a_cpu}, 32'd0);
        check("t2_ready_off", {31'b0, a_ready}, 32'd0);
        tick();
        check("t2_we_off", {31'b0, a_we}, 32'd0);
        check("t2_done", {31'b0, a_done}, 32'd1);
        check("t2_cpu", {31'b0, a_cpu}, 32'd1);
        check("t2_count", {25'b0, a_count}, 32'd1);
        check("t2_hold_data", a_wdata, 32'h00221820);

        // ---- 3: back-to-back lw/sw/beq ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t3_count0", {25'b0, a_count}, 32'd0);
        check("t3_done_clr", {31'b0, a_done}, 32'd0);
        check("t3_cpu_clr", {31'b0, a_cpu}, 32'd0);
        beat(2'b01, 5'd0, 5'd8, 5'd31, 6'h3F, 16'h0004, 1'b0);
        tick();
        chk_wr_a("t3_lw", 6'd0, 32'h8C080004);
        beat(2'b10, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0008, 1'b0);
        tick();
        chk_wr_a("t3_sw", 6'd1, 32'hAC080008);
        beat(2'b11, 5'd8, 5'd9, 5'd0, 6'h00, 16'hFFFF, 1'b1);
        tick();
        idle_in();
        chk_wr_a("t3_beq", 6'd2, 32'h1109FFFF);
        check("t3_count", {25'b0, a_count}, 32'd3);
        tick();
        check("t3_done", {31'b0, a_done}, 32'd1);
        check("t3_ovf", {31'b0, a_ovf}, 32'd0);

        // ---- 4: fill 4-word memory without last ----
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("t4_ready", {31'b0, b_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            beat(2'b01, 5'd2, 5'(i), 5'd0, 6'd0, 16'(i * 4), 1'b0);
            tick();
            check("t4_we", {31'b0, b_we}, 32'd1);
            check("t4_addr", {30'b0, b_addr}, i);
            check("t4_data", b_wdata, 32'h8C400000 | (i << 16) | (i * 4));
        end
        check("t4_ovf", {31'b0, b_ovf}, 32'd1);
        check("t4_ready_off", {31'b0, b_ready}, 32'd0);
        check("t4_cpu_held", {31'b0, b_cpu}, 32'd0);
        // 5th beat stays valid and must not be taken.
        tick();
        check("t4_no5th_we", {31'b0, b_we}, 32'd0);
        check("t4_done", {31'b0, b_done}, 32'd1);
        check("t4_count", {29'b0, b_count}, 32'd4);
        tick();
        check("t4_no5th_we2", {31'b0, b_we}, 32'd0);
        check("t4_count_sat", {29'b0, b_count}, 32'd4);
        idle_in();
        // Restart clears overflow; a 1-word program does not overflow.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("t4_ovf_clr", {31'b0, b_ovf}, 32'd0);
        beat(2'b00, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 1'b1);
        tick();
        idle_in();
        check("t4_re_addr", {30'b0, b_addr}, 32'd0);
        check("t4_re_data", b_wdata, 32'h00853022);
        tick();
        check("t4_re_ovf", {31'b0, b_ovf}, 32'd0);
        check("t4_re_count", {29'b0, b_count}, 32'd1);

        // ---- 5: gaps and stray start during LOAD ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        beat(2'b00, 5'd1, 5'd1, 5'd1, 6'h24, 16'h0, 1'b0);
        tick();
        idle_in();
        start_a = 1'b1;
        chk_wr_a("t5_b0", 6'd0, 32'h00210824);
        tick();
        start_a = 1'b0;
        check("t5_gap_we", {31'b0, a_we}, 32'd0);
        check("t5_gap_count", {25'b0, a_count}, 32'd1);
        check("t5_gap_hold", a_wdata, 32'h00210824);
        tick();
        check("t5_gap2_we", {31'b0, a_we}, 32'd0);
        beat(2'b10, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 1'b0);
        tick();
        idle_in();
        chk_wr_a("t5_b1", 6'd1, 32'hAC640010);
        tick();
        beat(2'b11, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0002, 1'b1);
        tick();
        chk_wr_a("t5_b2", 6'd2, 32'h10000002);
        beat(2'b01, 5'd7, 5'd7, 5'd0, 6'd0, 16'h1234, 1'b0);  // held into DRAIN/DONE
        tick();
        check("t5_drain_we", {31'b0, a_we}, 32'd0);
        tick();
        check("t5_done_we", {31'b0, a_we}, 32'd0);
        check("t5_count", {25'b0, a_count}, 32'd3);
        check("t5_done", {31'b0, a_done}, 32'd1);
        idle_in();

        // ---- 6: async reset mid-session, then fresh session ----
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        beat(2'b01, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0001, 1'b0);
        tick();
        tick();
        check("t6_pre_count", {25'b0, a_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_we", {31'b0, a_we}, 32'd0);
        check("t6_rst_count", {25'b0, a_count}, 32'd0);
        check("t6_rst_ready", {31'b0, a_ready}, 32'd0);
        check("t6_rst_wdata", a_wdata, 32'd0);
        check("t6_rst_cpu", {31'b0, a_cpu}, 32'd0);
        idle_in();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_idle_cpu", {31'b0, a_cpu}, 32'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        beat(2'b00, 5'd9, 5'd10, 5'd11, 6'h25, 16'h0, 1'b0);
        tick();
        chk_wr_a("t6_b0", 6'd0, 32'h012A5825);
        check("t6_cpu_held", {31'b0, a_cpu}, 32'd0);
        beat(2'b01, 5'd9, 5'd10, 5'd0, 6'd0, 16'h0020, 1'b1);
        tick();
        idle_in();
        chk_wr_a("t6_b1", 6'd1, 32'h8D2A0020);
        check("t6_cpu_held2", {31'b0, a_cpu}, 32'd0);
        tick();
        check("t6_cpu", {31'b0, a_cpu}, 32'd1);
        check("t6_count", {25'b0, a_count}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no end of sequence, expected completion");
        $fatal(1, "timeout");
    end

endmodule
